// File: rtl/c1541_gcr_track.sv
// Rotates a GCR track image from an external byte buffer, serialising it at the zone bit rate into din/byte_n/sync_n; write mode stores dout back.
// din/byte_n/sync_n change on the bit-tick edge; buffer data is expected one clk after buf_addr; mtr=0 or buf_busy=1 freezes rotation.
module c1541_gcr_track (
  input  logic        i_clk,
  input  logic        i_reset_n,
  input  logic        i_ce,
  input  logic        i_mtr,
  input  logic [1:0]  i_freq,
  input  logic        i_mode,
  input  logic [7:0]  i_dout,
  input  logic        i_wps_n,
  input  logic [12:0] i_track_len,
  input  logic        i_buf_busy,
  output logic [12:0] o_buf_addr,
  input  logic [7:0]  i_buf_din,
  output logic [7:0]  o_buf_dout,
  output logic        o_buf_we,
  output logic [7:0]  o_din,
  output logic        o_sync_n,
  output logic        o_byte_n
);

  logic [5:0]  r_timer;
  logic [1:0]  r_zone;
  logic [2:0]  r_bidx;
  logic [12:0] r_addr;
  logic        r_adv;
  logic [7:0]  r_tsr;
  logic [7:0]  r_rsr;
  logic [3:0]  r_ones;
  logic [3:0]  r_rbc;
  logic [7:0]  r_din;
  logic [4:0]  r_bcnt;
  logic        r_wmode;
  logic [7:0]  r_wlat;
  logic        r_wvld;
  logic        r_we;
  logic [7:0]  r_bdout;

  logic        w_rot;
  logic [5:0]  w_period_m1;
  logic        w_tick;
  logic        w_first;
  logic        w_last;
  logic        w_bit;
  logic        w_wr;
  logic        w_rd_tick;
  logic        w_byte_wr;
  logic        w_byte_rd;
  logic        w_commit;
  logic        w_in_sync;
  logic        w_sync_end;
  logic [3:0]  w_ones_nxt;
  logic [3:0]  w_rbc_inc;
  logic [7:0]  w_rsr_nxt;
  logic [13:0] w_addr_inc;

  assign w_rot       = i_mtr & ~i_buf_busy & (i_track_len != 13'd0);
  assign w_period_m1 = 6'd63 - {2'b00, r_zone, 2'b00};
  assign w_tick      = w_rot & i_ce & (r_timer == w_period_m1);
  assign w_first     = (r_bidx == 3'd0);
  assign w_last      = (r_bidx == 3'd7);
  // At bit 0 the shift register still holds the previous byte, so take the bit straight from the buffer.
  assign w_bit       = w_first ? i_buf_din[7] : r_tsr[~r_bidx];

  // A pending read->write switch only lands on a byte boundary; write->read is immediate.
  assign w_wr        = ~i_mode & (r_wmode | w_first);
  assign w_rd_tick   = w_tick & ~w_wr;
  assign w_byte_wr   = w_tick & w_wr & w_first;
  assign w_commit    = w_tick & w_wr & w_last & r_wvld & i_wps_n;

  assign w_in_sync   = (r_ones >= 4'd10);
  assign w_sync_end  = ~w_bit & w_in_sync;
  assign w_ones_nxt  = ~w_bit ? 4'd0 : ((r_ones == 4'd15) ? 4'd15 : r_ones + 4'd1);
  assign w_rbc_inc   = r_rbc + 4'd1;
  assign w_rsr_nxt   = {r_rsr[6:0], w_bit};
  assign w_byte_rd   = w_rd_tick & ~w_sync_end & (w_ones_nxt < 4'd10) & (w_rbc_inc == 4'd8);
  assign w_addr_inc  = {1'b0, r_addr} + 14'd1;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_timer <= 6'd0;
      r_zone  <= 2'd0;
      r_bidx  <= 3'd0;
      r_tsr   <= 8'd0;
      r_adv   <= 1'b0;
      r_addr  <= 13'd0;
    end else begin
      if (w_tick) begin
        r_timer <= 6'd0;
        r_zone  <= i_freq;
        r_bidx  <= r_bidx + 3'd1;
        if (w_first) r_tsr <= i_buf_din;
      end else if (w_rot && i_ce) begin
        r_timer <= r_timer + 6'd1;
      end
      // Advance one clk after the last bit so a write strobe still sees the old address.
      r_adv <= w_tick & w_last;
      if (r_adv) r_addr <= (w_addr_inc >= {1'b0, i_track_len}) ? 13'd0 : w_addr_inc[12:0];
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_rsr  <= 8'd0;
      r_ones <= 4'd0;
      r_rbc  <= 4'd0;
      r_din  <= 8'hFF;
    end else if (w_rd_tick) begin
      r_rsr <= w_rsr_nxt;
      if (w_sync_end) begin
        r_rbc  <= 4'd1;
        r_ones <= 4'd0;
      end else begin
        r_ones <= w_ones_nxt;
        r_rbc  <= ((w_ones_nxt >= 4'd10) || (w_rbc_inc == 4'd8)) ? 4'd0 : w_rbc_inc;
      end
      if (w_byte_rd) r_din <= w_rsr_nxt;
    end else if (r_wmode || w_byte_wr) begin
      r_ones <= 4'd0;
      r_rbc  <= 4'd0;
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_wmode <= 1'b0;
      r_wlat  <= 8'd0;
      r_wvld  <= 1'b0;
      r_we    <= 1'b0;
      r_bdout <= 8'd0;
      r_bcnt  <= 5'd0;
    end else begin
      if (i_mode) r_wmode <= 1'b0;
      else if (w_tick && w_first) r_wmode <= 1'b1;
      if (w_byte_wr) r_wlat <= i_dout;
      // A byte interrupted by a stall or mode change is never committed.
      if (i_mode || !w_rot || (w_tick && w_last)) r_wvld <= 1'b0;
      else if (w_byte_wr) r_wvld <= 1'b1;
      r_we <= w_commit;
      if (w_commit) r_bdout <= r_wlat;
      if (w_byte_rd || w_byte_wr) r_bcnt <= 5'd16;
      else if (i_ce && (r_bcnt != 5'd0)) r_bcnt <= r_bcnt - 5'd1;
    end
  end

  assign o_buf_addr = r_addr;
  assign o_buf_dout = r_bdout;
  assign o_buf_we   = r_we;
  assign o_din      = r_din;
  assign o_sync_n   = ~(w_rot & w_in_sync);
  assign o_byte_n   = ~(w_rot & (r_bcnt != 5'd0));

endmodule
